// File: rtl/qf_rw_bank.sv
// rtl/qf_rw_bank.sv - parametrised register bank with RW/RO/W1C/PULSE modes; optional write lock via QF_RW_BANK_LOCK_EN
module qf_rw_bank #(
    parameter int PAR_BIT_WIDTH  = 32,
    parameter int PAR_NUM_REGS   = 8,
    parameter int PAR_ADDR_WIDTH = 3,
    parameter logic [PAR_NUM_REGS*PAR_BIT_WIDTH-1:0] PAR_DEFAULT_VALUE = '0,
    parameter logic [2*PAR_NUM_REGS-1:0]             PAR_MODE          = '0
) (
`ifdef QF_RW_BANK_LOCK_EN
    input  logic                                   lock,
`endif
    input  logic                                   sys_clk,
    input  logic                                   sys_rst,
    input  logic                                   wr_en,
    input  logic [PAR_ADDR_WIDTH-1:0]              wr_addr,
    input  logic [PAR_BIT_WIDTH-1:0]               wrdata,
    input  logic [PAR_BIT_WIDTH/8-1:0]             wr_be,
    input  logic                                   rd_en,
    input  logic [PAR_ADDR_WIDTH-1:0]              rd_addr,
    output logic [PAR_BIT_WIDTH-1:0]               rddata,
    output logic                                   rd_valid,
    output logic                                   wr_err,
    output logic                                   rd_err,
    input  logic [PAR_NUM_REGS*PAR_BIT_WIDTH-1:0]  hw_status,
    input  logic [PAR_NUM_REGS*PAR_BIT_WIDTH-1:0]  hw_set,
    output logic [PAR_NUM_REGS*PAR_BIT_WIDTH-1:0]  reg_q,
    output logic                                   irq
);

    localparam int NB = PAR_BIT_WIDTH / 8;

    localparam logic [1:0] MODE_RW    = 2'b00;
    localparam logic [1:0] MODE_RO    = 2'b01;
    localparam logic [1:0] MODE_W1C   = 2'b10;
    localparam logic [1:0] MODE_PULSE = 2'b11;

    localparam logic [PAR_ADDR_WIDTH:0] NUM_REGS_W = (PAR_ADDR_WIDTH+1)'(PAR_NUM_REGS);

    logic [PAR_BIT_WIDTH-1:0] regs_q [PAR_NUM_REGS];
    logic [PAR_BIT_WIDTH-1:0] regs_d [PAR_NUM_REGS];

    logic [PAR_BIT_WIDTH-1:0] be_mask;
    logic [1:0]               wr_mode;
    logic                     wr_addr_ok;
    logic                     rd_addr_ok;
    logic                     lock_active;
    logic                     wr_illegal;
    logic                     wr_ok;
    logic [PAR_BIT_WIDTH-1:0] rd_sel;
    logic                     irq_d;

    logic [PAR_BIT_WIDTH-1:0] rddata_q;
    logic                     rd_valid_q;
    logic                     rd_err_q;
    logic                     wr_err_q;
    logic                     irq_q;

`ifdef QF_RW_BANK_LOCK_EN
    assign lock_active = lock;
`else
    assign lock_active = 1'b0;
`endif

    assign wr_addr_ok = ({1'b0, wr_addr} < NUM_REGS_W);
    assign rd_addr_ok = ({1'b0, rd_addr} < NUM_REGS_W);

    // Expand byte enables into a per-bit write mask
    always_comb begin
        be_mask = '0;
        for (int b = 0; b < NB; b++) begin
            be_mask[b*8 +: 8] = {8{wr_be[b]}};
        end
    end

    // Mode of the addressed register and write legality (RO target, bad address, or lock)
    always_comb begin
        wr_mode = MODE_RW;
        for (int i = 0; i < PAR_NUM_REGS; i++) begin
            if (wr_addr == PAR_ADDR_WIDTH'(i)) begin
                wr_mode = PAR_MODE[2*i +: 2];
            end
        end
        wr_illegal = !wr_addr_ok
                   || (wr_mode == MODE_RO)
                   || (lock_active && ((wr_mode == MODE_RW) || (wr_mode == MODE_PULSE)));
        wr_ok = wr_en && !wr_illegal;
    end

    // Next-state for every register according to its access mode
    always_comb begin
        for (int i = 0; i < PAR_NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            case (PAR_MODE[2*i +: 2])
                MODE_RW: begin
                    if (wr_ok && (wr_addr == PAR_ADDR_WIDTH'(i))) begin
                        regs_d[i] = (regs_q[i] & ~be_mask) | (wrdata & be_mask);
                    end
                end
                MODE_RO: begin
                    regs_d[i] = hw_status[i*PAR_BIT_WIDTH +: PAR_BIT_WIDTH];
                end
                MODE_W1C: begin
                    // Hardware set is OR-ed in after the clear so a same-cycle set wins
                    if (wr_ok && (wr_addr == PAR_ADDR_WIDTH'(i))) begin
                        regs_d[i] = (regs_q[i] & ~(wrdata & be_mask))
                                  | hw_set[i*PAR_BIT_WIDTH +: PAR_BIT_WIDTH];
                    end else begin
                        regs_d[i] = regs_q[i] | hw_set[i*PAR_BIT_WIDTH +: PAR_BIT_WIDTH];
                    end
                end
                default: begin
                    // PULSE: written bytes live for one cycle, everything else sits at default
                    if (wr_ok && (wr_addr == PAR_ADDR_WIDTH'(i))) begin
                        regs_d[i] = (PAR_DEFAULT_VALUE[i*PAR_BIT_WIDTH +: PAR_BIT_WIDTH] & ~be_mask)
                                  | (wrdata & be_mask);
                    end else begin
                        regs_d[i] = PAR_DEFAULT_VALUE[i*PAR_BIT_WIDTH +: PAR_BIT_WIDTH];
                    end
                end
            endcase
        end
    end

    // Read mux and interrupt reduction over the current register contents
    always_comb begin
        rd_sel = '0;
        irq_d  = 1'b0;
        for (int i = 0; i < PAR_NUM_REGS; i++) begin
            if (rd_addr == PAR_ADDR_WIDTH'(i)) begin
                rd_sel = regs_q[i];
            end
            if (PAR_MODE[2*i +: 2] == MODE_W1C) begin
                irq_d = irq_d | (|regs_q[i]);
            end
        end
    end

    // Register array update; reset overrides any concurrent write
    always_ff @(posedge sys_clk) begin
        for (int i = 0; i < PAR_NUM_REGS; i++) begin
            if (sys_rst) begin
                regs_q[i] <= PAR_DEFAULT_VALUE[i*PAR_BIT_WIDTH +: PAR_BIT_WIDTH];
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Registered read port, error pulses and interrupt
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rddata_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            rd_err_q   <= rd_en && !rd_addr_ok;
            if (rd_en) begin
                rddata_q <= rd_addr_ok ? rd_sel : '0;
            end
            wr_err_q   <= wr_en && wr_illegal;
            irq_q      <= irq_d;
        end
    end

    assign rddata   = rddata_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
    assign wr_err   = wr_err_q;
    assign irq      = irq_q;

    genvar g;
    generate
        for (g = 0; g < PAR_NUM_REGS; g++) begin : g_reg_out
            assign reg_q[g*PAR_BIT_WIDTH +: PAR_BIT_WIDTH] = regs_q[g];
        end
    endgenerate

endmodule

// File: tb/tb_qf_rw_bank.sv
// tb/tb_qf_rw_bank.sv - self-checking bench for qf_rw_bank with reference model
module tb_qf_rw_bank;

    localparam int W = 32;
    localparam int N = 6;
    localparam int A = 3;

    localparam logic [N*W-1:0] DEF  = {32'h0, 32'h0, 32'h0000_F000, 32'h0, 32'h0, 32'hA5A5_0000};
    localparam logic [2*N-1:0] MODE = 12'h9E0;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic [A-1:0]     wr_addr = '0;
    logic [W-1:0]     wrdata = '0;
    logic [W/8-1:0]   wr_be = '0;
    logic             rd_en = 1'b0;
    logic [A-1:0]     rd_addr = '0;
    logic [W-1:0]     rddata;
    logic             rd_valid;
    logic             wr_err;
    logic             rd_err;
    logic [N*W-1:0]   hw_status = '0;
    logic [N*W-1:0]   hw_set = '0;
    logic [N*W-1:0]   reg_q;
    logic             irq;
    logic             lock_in = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model: mode 0 RW, 1 RO, 2 W1C, 3 PULSE
    int          mode_m [N] = '{0, 0, 2, 3, 1, 2};
    logic [31:0] def_m  [N] = '{32'hA5A5_0000, 32'h0, 32'h0, 32'h0000_F000, 32'h0, 32'h0};
    logic [31:0] m_reg  [N];
    logic [31:0] m_rddata = '0;
    logic        m_rd_valid = 1'b0;
    logic        m_rd_err = 1'b0;
    logic        m_wr_err = 1'b0;
    logic        m_irq = 1'b0;

    qf_rw_bank #(
        .PAR_BIT_WIDTH    (W),
        .PAR_NUM_REGS     (N),
        .PAR_ADDR_WIDTH   (A),
        .PAR_DEFAULT_VALUE(DEF),
        .PAR_MODE         (MODE)
    ) dut (
`ifdef QF_RW_BANK_LOCK_EN
        .lock     (lock_in),
`endif
        .sys_clk  (clk),
        .sys_rst  (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wrdata   (wrdata),
        .wr_be    (wr_be),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rddata   (rddata),
        .rd_valid (rd_valid),
        .wr_err   (wr_err),
        .rd_err   (rd_err),
        .hw_status(hw_status),
        .hw_set   (hw_set),
        .reg_q    (reg_q),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [31:0] nxt [N];
        logic [31:0] wm;
        logic [31:0] s;
        logic        bad;
        logic        any;
        if (rst) begin
            for (int i = 0; i < N; i++) m_reg[i] = def_m[i];
            m_rddata = '0; m_rd_valid = 0; m_rd_err = 0; m_wr_err = 0; m_irq = 0;
        end else begin
            any = 0;
            for (int i = 0; i < N; i++) if (mode_m[i] == 2 && m_reg[i] != 0) any = 1;
            m_rd_valid = rd_en;
            m_rd_err   = 0;
            if (rd_en) begin
                if (rd_addr < N) m_rddata = m_reg[rd_addr];
                else begin m_rddata = 0; m_rd_err = 1; end
            end
            bad = 0;
            if (wr_en) begin
                if (wr_addr >= N) bad = 1;
                else if (mode_m[wr_addr] == 1) bad = 1;
                else if (lock_in && (mode_m[wr_addr] == 0 || mode_m[wr_addr] == 3)) bad = 1;
            end
            m_wr_err = bad;
            for (int i = 0; i < N; i++) begin
                wm = 0;
                if (wr_en && !bad && wr_addr == i)
                    for (int b = 0; b < 4; b++) if (wr_be[b]) wm[b*8 +: 8] = 8'hFF;
                s = hw_set[i*W +: W];
                case (mode_m[i])
                    0: nxt[i] = (m_reg[i] & ~wm) | (wrdata & wm);
                    1: nxt[i] = hw_status[i*W +: W];
                    2: nxt[i] = ((m_reg[i] | s) & ~(wrdata & wm)) | s;
                    default: nxt[i] = (def_m[i] & ~wm) | (wrdata & wm);
                endcase
            end
            for (int i = 0; i < N; i++) m_reg[i] = nxt[i];
            m_irq = any;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) check($sformatf("reg%0d", i), reg_q[i*W +: W], m_reg[i]);
        check("rddata", rddata, m_rddata);
        check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
        check("rd_err", 32'(rd_err), 32'(m_rd_err));
        check("wr_err", 32'(wr_err), 32'(m_wr_err));
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        // reset
        rst = 1; tick(); rst = 0;
        check("rst_reg0", reg_q[0 +: W], 32'hA5A5_0000);

        // reset value read back
        rd_en = 1; rd_addr = 0; tick(); rd_en = 0;
        check("rd_reg0", rddata, 32'hA5A5_0000);
        check("rd_reg0_valid", 32'(rd_valid), 32'h1);
        check("irq_idle", 32'(irq), 32'h0);

        // byte-enabled RW write with same-cycle read returning the old value
        wr_en = 1; wr_addr = 1; wrdata = 32'h1122_3344; wr_be = 4'b0101;
        rd_en = 1; rd_addr = 1; tick(); wr_en = 0;
        check("rw_old_read", rddata, 32'h0);
        check("rw_be_value", reg_q[1*W +: W], 32'h0022_0044);
        tick(); rd_en = 0;
        check("rw_new_read", rddata, 32'h0022_0044);

        // W1C set, irq, set-vs-clear race, clear
        hw_set[2*W + 3] = 1'b1; tick(); hw_set = '0;
        check("w1c_set", reg_q[2*W +: W], 32'h8);
        tick();
        check("w1c_irq_hi", 32'(irq), 32'h1);
        wr_en = 1; wr_addr = 2; wrdata = 32'h8; wr_be = 4'hF; hw_set[2*W + 3] = 1'b1; tick(); hw_set = '0;
        check("w1c_race", reg_q[2*W +: W], 32'h8);
        tick(); wr_en = 0;
        check("w1c_clear", reg_q[2*W +: W], 32'h0);
        tick();
        check("w1c_irq_lo", 32'(irq), 32'h0);

        // PULSE register lives one cycle then returns to default
        wr_en = 1; wr_addr = 3; wrdata = 32'h1; wr_be = 4'hF; tick(); wr_en = 0;
        check("pulse_on", reg_q[3*W +: W], 32'h1);
        tick();
        check("pulse_off", reg_q[3*W +: W], 32'h0000_F000);

        // RO write is rejected
        hw_status[4*W +: W] = 32'hDEAD;
        wr_en = 1; wr_addr = 4; wrdata = 32'hFFFF_FFFF; wr_be = 4'hF; tick(); wr_en = 0;
        check("ro_wr_err", 32'(wr_err), 32'h1);
        check("ro_value", reg_q[4*W +: W], 32'hDEAD);
        tick();
        check("ro_wr_err_clr", 32'(wr_err), 32'h0);

        // out-of-range addresses
        wr_en = 1; wr_addr = 7; wrdata = 32'hFFFF_FFFF; wr_be = 4'hF;
        rd_en = 1; rd_addr = 6; tick(); wr_en = 0; rd_en = 0;
        check("bad_wr_err", 32'(wr_err), 32'h1);
        check("bad_rd_err", 32'(rd_err), 32'h1);
        check("bad_rd_valid", 32'(rd_valid), 32'h1);
        check("bad_rddata", rddata, 32'h0);
        check("bad_reg1_hold", reg_q[1*W +: W], 32'h0022_0044);

        // zero byte-enable write is legal and changes nothing
        wr_en = 1; wr_addr = 1; wrdata = 32'hFFFF_FFFF; wr_be = 4'h0; tick(); wr_en = 0;
        check("be0_no_err", 32'(wr_err), 32'h0);
        check("be0_hold", reg_q[1*W +: W], 32'h0022_0044);

`ifdef QF_RW_BANK_LOCK_EN
        // lock blocks RW writes but W1C clears still go through
        hw_set[2*W + 5] = 1'b1; tick(); hw_set = '0;
        lock_in = 1;
        wr_en = 1; wr_addr = 1; wrdata = 32'hFFFF_FFFF; wr_be = 4'hF; tick();
        check("lock_wr_err", 32'(wr_err), 32'h1);
        check("lock_reg1", reg_q[1*W +: W], 32'h0022_0044);
        wr_addr = 2; wrdata = 32'h20; tick(); wr_en = 0;
        check("lock_w1c_ok", 32'(wr_err), 32'h0);
        check("lock_w1c_clr", reg_q[2*W +: W], 32'h0);
        lock_in = 0;
`endif

        // reset during a write: defaults win
        rst = 1; wr_en = 1; wr_addr = 1; wrdata = 32'hFFFF_FFFF; wr_be = 4'hF; tick();
        rst = 0; wr_en = 0;
        check("midrst_reg1", reg_q[1*W +: W], 32'h0);
        check("midrst_reg0", reg_q[0 +: W], 32'hA5A5_0000);
        check("midrst_wr_err", 32'(wr_err), 32'h0);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 199) == 0);
            wr_en   = $urandom_range(0, 1);
            wr_addr = A'($urandom_range(0, 7));
            wrdata  = $urandom;
            wr_be   = 4'($urandom);
            rd_en   = $urandom_range(0, 1);
            rd_addr = A'($urandom_range(0, 7));
            for (int i = 0; i < N; i++) begin
                hw_status[i*W +: W] = $urandom;
                hw_set[i*W +: W] = ($urandom_range(0, 7) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
            end
`ifdef QF_RW_BANK_LOCK_EN
            lock_in = ($urandom_range(0, 3) == 0);
`endif
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
